down_counter: RTL and testbench
===============================

DOWN_COUNTER -- requirements
Module: down_counter

Interface
REQ-001 The block SHALL have parameter WIDTH, default 4, giving the counter width in bits.
REQ-002 clk  input  1  The single clock; all state SHALL update on the rising edge.
REQ-003 reset  input  1  Asynchronous, active-low reset; reset=0 SHALL force the reset state immediately, regardless of clk.
REQ-004 load  input  1  Load strobe; samples load_val into the count and reload registers.
REQ-005 load_val  input  WIDTH  Start/reload value.
REQ-006 en  input  1  Count enable; the count decrements only when en=1.
REQ-007 auto_reload  input  1  Mode select: 1 = periodic reload at terminal, 0 = one-shot.
REQ-008 cout  output  WIDTH  Current count value, registered.
REQ-009 tc  output  1  Terminal-count pulse, registered, high for exactly one cycle.
REQ-010 busy  output  1  High when state=RUN; decoded from the state register only.

Function
REQ-011 The block SHALL implement a three-state FSM: IDLE, RUN, EXPIRED.
REQ-012 The block SHALL hold an internal reload register of WIDTH bits, written only on load.
REQ-013 When load=1 in any state, cout and the reload register SHALL take load_val on the next edge, and load SHALL take priority over en and over terminal detection.
REQ-014 If load_val!=0 at load, state SHALL become RUN.
REQ-015 If load_val=0 at load, state SHALL become EXPIRED and tc SHALL stay 0.
REQ-016 In IDLE or EXPIRED with load=0, cout SHALL hold, state SHALL hold, and en SHALL be ignored.
REQ-017 In RUN with en=0 and load=0, cout and state SHALL hold.
REQ-018 In RUN with en=1, load=0 and cout>1, cout SHALL decrement by 1 per edge.
REQ-019 In RUN with en=1, load=0 and cout=1, tc SHALL be 1 on the next cycle.
REQ-020 In the terminal case of REQ-019 with auto_reload=1, cout SHALL take the reload value and state SHALL stay RUN, so cout never shows 0.
REQ-021 In the terminal case of REQ-019 with auto_reload=0, cout SHALL become 0 and state SHALL become EXPIRED.
REQ-022 auto_reload SHALL be sampled only on the terminal edge and SHALL have no effect otherwise.
REQ-023 tc SHALL be 0 in every cycle not immediately following a terminal edge, so consecutive tc pulses are separated by at least one low cycle unless the reload value is 1.
REQ-024 With reload value 1, auto_reload=1 and en held high, tc SHALL be high every cycle and cout SHALL stay 1.
REQ-025 When load and terminal conditions coincide, load SHALL win and tc SHALL be 0 on the next cycle.
REQ-026 Count arithmetic SHALL be unsigned modulo 2^WIDTH, and the count SHALL never wrap below 0 (no underflow past 0).
REQ-027 busy SHALL be 1 in RUN and 0 in IDLE and EXPIRED.

Reset
REQ-028 When reset=0, the block SHALL set cout=0, reload=0, tc=0, state=IDLE and busy=0 asynchronously.
REQ-029 A reset assertion mid-count SHALL abort the count with no tc pulse.
REQ-030 After reset deasserts, the block SHALL stay in IDLE until the first load.
REQ-031 Reset deassertion SHALL be used synchronously to clk in the block, with no other reset path.

Verification
REQ-032 One-shot count: reset, then load_val=5, auto_reload=0, en=1 -> cout 5,4,3,2,1,0 on successive edges; tc=1 only in the cycle where cout=0; busy falls with the 0; state EXPIRED.
REQ-033 Periodic count: load_val=3, auto_reload=1, en=1 for 9 edges -> cout 3,2,1,3,2,1,3,2,1; tc pulses in the cycles after each 1 (the cycles showing 3, cycles 4 and 7); busy stays 1.
REQ-034 Enable gating: load 4, en toggled 1,0,0,1 -> cout 4,3,3,3,2; no tc.
REQ-035 Load collision: cout=1 in RUN, en=1 and load=1 with load_val=9 on the same edge -> cout=9, tc=0, state RUN.
REQ-036 Async reset: reset=0 between clock edges while cout=6 -> cout=0, busy=0, tc=0 before the next edge; with en=1 after release and no load, cout stays 0.
REQ-037 Zero load and ceiling: load_val=0 -> state EXPIRED, busy=0, tc never 1; load_val=15 with WIDTH=4 -> 15 distinct decrements to 0 with no wrap.

Source files
------------

// File: rtl/down_counter.sv
// down_counter: loadable down counter with one-shot / periodic auto-reload.
// A three-state FSM (IDLE, RUN, EXPIRED) tracks whether a count is active.
// A load always wins. tc is a registered one-cycle pulse that follows each
// terminal edge, which is the edge where cout steps down from 1.
module down_counter #(
    parameter int WIDTH = 4
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             load,
    input  logic [WIDTH-1:0] load_val,
    input  logic             en,
    input  logic             auto_reload,
    output logic [WIDTH-1:0] cout,
    output logic             tc,
    output logic             busy
);

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        RUN     = 2'd1,
        EXPIRED = 2'd2
    } state_t;

    localparam logic [WIDTH-1:0] ZERO = '0;
    localparam logic [WIDTH-1:0] ONE  = {{(WIDTH-1){1'b0}}, 1'b1};

    state_t           state_reg, state_next;
    logic [WIDTH-1:0] count_reg, count_next;
    logic [WIDTH-1:0] reload_reg, reload_next;
    logic             tc_reg, tc_next;

    // State and datapath registers.
    // Reset clears these registers asynchronously.
    // The first load after reset release is sampled on an ordinary clock edge.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_reg  <= IDLE;
            count_reg  <= ZERO;
            reload_reg <= ZERO;
            tc_reg     <= 1'b0;
        end else begin
            state_reg  <= state_next;
            count_reg  <= count_next;
            reload_reg <= reload_next;
            tc_reg     <= tc_next;
        end
    end

    // Next-state and datapath logic.
    // A load overrides both en and terminal detection.
    always_comb begin
        state_next  = state_reg;
        count_next  = count_reg;
        reload_next = reload_reg;
        tc_next     = 1'b0;

        if (load) begin
            count_next  = load_val;
            reload_next = load_val;
            // A zero load has nothing to count, so it expires without a tc pulse.
            state_next  = (load_val != ZERO) ? RUN : EXPIRED;
        end else if (state_reg == RUN && en) begin
            if (count_reg == ONE) begin
                // Terminal edge: auto_reload is sampled only here.
                tc_next = 1'b1;
                if (auto_reload) begin
                    count_next = reload_reg;
                end else begin
                    count_next = ZERO;
                    state_next = EXPIRED;
                end
            end else if (count_reg == ZERO) begin
                // RUN with a zero count cannot occur. Retire without
                // underflowing if it ever does.
                state_next = EXPIRED;
            end else begin
                count_next = count_reg - ONE;
            end
        end
    end

    // Outputs come straight from registers.
    // busy is a pure decode of the state register.
    assign cout = count_reg;
    assign tc   = tc_reg;
    assign busy = (state_reg == RUN);

endmodule

// File: tb/tb_down_counter.sv
// Directed self-checking bench for down_counter (WIDTH=4).
// Inputs change 1ns after a rising edge. Outputs are checked at that same point.
module tb_down_counter;

    localparam int WIDTH = 4;

    logic             clk = 1'b0;
    logic             reset = 1'b0;
    logic             load = 1'b0;
    logic [WIDTH-1:0] load_val = '0;
    logic             en = 1'b0;
    logic             auto_reload = 1'b0;
    logic [WIDTH-1:0] cout;
    logic             tc;
    logic             busy;

    int errors = 0;
    int checks = 0;

    down_counter #(.WIDTH(WIDTH)) dut (
        .clk         (clk),
        .reset       (reset),
        .load        (load),
        .load_val    (load_val),
        .en          (en),
        .auto_reload (auto_reload),
        .cout        (cout),
        .tc          (tc),
        .busy        (busy)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    task automatic expect_out(input string tag, input int c, input int t, input int b);
        check({tag, ".cout"}, 32'(cout), c);
        check({tag, ".tc"},   32'(tc),   t);
        check({tag, ".busy"}, 32'(busy), b);
        $display("%s: cout=%0d tc=%0d busy=%0d", tag, cout, tc, busy);
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Applies a one-cycle load strobe. On return, the load edge has passed.
    task automatic do_load(input int v, input logic ar, input logic e);
        load        = 1'b1;
        load_val    = v[WIDTH-1:0];
        auto_reload = ar;
        en          = e;
        step();
        load = 1'b0;
    endtask

    int one_shot_exp [5]  = '{4, 3, 2, 1, 0};
    int periodic_exp [8]  = '{2, 1, 3, 2, 1, 3, 2, 1};
    int periodic_tc  [8]  = '{0, 0, 1, 0, 0, 1, 0, 0};
    int gate_en      [4]  = '{1, 0, 0, 1};
    int gate_exp     [4]  = '{3, 3, 3, 2};

    initial begin
        #100000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "timeout");
    end

    initial begin
        // Reset state
        repeat (2) step();
        expect_out("reset", 0, 0, 0);
        @(negedge clk);
        reset = 1'b1;
        en    = 1'b1;
        // The counter stays in IDLE with en ignored until the first load.
        repeat (3) step();
        expect_out("idle_no_load", 0, 0, 0);

        // One-shot count from 5
        do_load(5, 1'b0, 1'b1);
        expect_out("oneshot_load", 5, 0, 1);
        for (int i = 0; i < 5; i++) begin
            step();
            expect_out($sformatf("oneshot[%0d]", i), one_shot_exp[i],
                       (one_shot_exp[i] == 0) ? 1 : 0, (one_shot_exp[i] != 0) ? 1 : 0);
        end
        step();
        expect_out("expired_hold", 0, 0, 0);

        // Periodic count with reload value 3
        do_load(3, 1'b1, 1'b1);
        expect_out("periodic_load", 3, 0, 1);
        for (int i = 0; i < 8; i++) begin
            step();
            expect_out($sformatf("periodic[%0d]", i), periodic_exp[i], periodic_tc[i], 1);
        end

        // Enable gating
        do_load(4, 1'b0, 1'b1);
        expect_out("gate_load", 4, 0, 1);
        for (int i = 0; i < 4; i++) begin
            en = gate_en[i][0];
            step();
            expect_out($sformatf("gate[%0d]", i), gate_exp[i], 0, 1);
        end

        // Load that coincides with a terminal edge
        en = 1'b1;
        step();
        expect_out("collide_pre", 1, 0, 1);
        do_load(9, 1'b0, 1'b1);
        en = 1'b0;
        expect_out("collide", 9, 0, 1);

        // Asynchronous reset between clock edges while a count is active
        do_load(6, 1'b0, 1'b0);
        expect_out("async_pre", 6, 0, 1);
        en = 1'b1;
        @(posedge clk);
        #3;
        reset = 1'b0;
        #1;
        expect_out("async_reset", 0, 0, 0);
        @(negedge clk);
        reset = 1'b1;
        step();
        step();
        expect_out("after_release", 0, 0, 0);

        // Zero load
        do_load(0, 1'b1, 1'b1);
        expect_out("zero_load", 0, 0, 0);
        step();
        expect_out("zero_hold", 0, 0, 0);

        // Ceiling count from 15 down to 0 with no wrap
        do_load(15, 1'b0, 1'b1);
        expect_out("ceil_load", 15, 0, 1);
        for (int v = 14; v >= 0; v--) begin
            step();
            expect_out($sformatf("ceil[%0d]", v), v, (v == 0) ? 1 : 0, (v != 0) ? 1 : 0);
        end
        step();
        expect_out("ceil_nowrap", 0, 0, 0);

        // Reload value 1: tc is high every cycle
        do_load(1, 1'b1, 1'b1);
        expect_out("rl1_load", 1, 0, 1);
        for (int i = 0; i < 3; i++) begin
            step();
            expect_out($sformatf("rl1[%0d]", i), 1, 1, 1);
        end

        // auto_reload only matters on the terminal edge
        do_load(3, 1'b1, 1'b1);
        step();
        expect_out("ar_mid", 2, 0, 1);
        auto_reload = 1'b0;
        step();
        expect_out("ar_one", 1, 0, 1);
        step();
        expect_out("ar_term", 0, 1, 0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
